// File: rtl/vga_text_renderer.sv
// rtl/vga_text_renderer.sv - 800x600 VGA text renderer with a 4-stage text/font fetch pipeline
// Optional cursor inversion: define VGA_TEXT_CURSOR_EN.
module vga_text_renderer #(
  parameter int FNT_W       = 4,
  parameter int FNT_H       = 6,
  parameter int FNT_C       = 16,
  parameter int CHR_BITS    = 4,
  parameter int FONT_ADDR_W = 7,
  parameter int PIX_W       = 10,
  parameter int PIX_H       = 5,
  parameter int COLS        = 16,
  parameter int ROWS        = 17,
  parameter int TXT_ADDR_W  = 9,
  parameter int RES_H       = 800,
  parameter int BLK_HF      = 40,
  parameter int BLK_HT      = 128,
  parameter int BLK_HB      = 88,
  parameter int RES_V       = 600,
  parameter int BLK_VF      = 1,
  parameter int BLK_VT      = 4,
  parameter int BLK_VB      = 23,
  parameter bit SYNC_POL    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [TXT_ADDR_W-1:0]     txt_addr,
  input  logic [CHR_BITS+5:0]       txt_data,
  output logic [FONT_ADDR_W-1:0]    font_addr,
  input  logic [FNT_W-1:0]          font_q,
  input  logic [$clog2(COLS)-1:0]   cursor_col,
  input  logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [2:0]                RGB,
  output logic                      HSYNC,
  output logic                      VSYNC,
  output logic                      frame_start
);
  localparam int H_TOTAL = RES_H + BLK_HF + BLK_HT + BLK_HB;
  localparam int V_TOTAL = RES_V + BLK_VF + BLK_VT + BLK_VB;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int SHW = $clog2(PIX_W + 1);
  localparam int SVW = $clog2(PIX_H + 1);
  localparam int CW  = $clog2(FNT_W + 1);
  localparam int LW  = $clog2(FNT_H + 1);

  if (COLS * ROWS > 2 ** TXT_ADDR_W) begin : g_chk_txt
    $error("COLS*ROWS exceeds text RAM address space");
  end
  if (FNT_H * FNT_C + 2 ** CHR_BITS > 2 ** FONT_ADDR_W) begin : g_chk_font
    $error("font ROM address space too small");
  end

  typedef struct packed {
    logic          cur;
    logic          fs;
    logic          vs;
    logic          hs;
    logic          grid;
    logic          vis;
    logic [LW-1:0] line;
    logic [CW-1:0] col;
  } attr_t;

  logic [HW-1:0]  r_cnt_h, r_cell_col;
  logic [VW-1:0]  r_cnt_v, r_cell_row;
  logic [SHW-1:0] r_sub_h;
  logic [SVW-1:0] r_sub_v;
  logic [CW-1:0]  r_col;
  logic [LW-1:0]  r_line;
  logic [3:1]     r_vld;
  attr_t          r_a1, r_a2, r_a3;
  logic [2:0]     r_fg2, r_bg2, r_fg3, r_bg3;
  logic [FNT_W-1:0] r_glyph3;
  attr_t          w_a0;
  logic           w_cur;
  logic [FNT_W-1:0] w_glyph_sh;

  // Cell coordinates are stepped alongside the raster counters instead of divided out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_h <= '0; r_sub_h <= '0; r_col <= '0; r_cell_col <= '0;
      r_cnt_v <= '0; r_sub_v <= '0; r_line <= '0; r_cell_row <= '0;
    end else if (r_cnt_h == HW'(H_TOTAL - 1)) begin
      r_cnt_h <= '0; r_sub_h <= '0; r_col <= '0; r_cell_col <= '0;
      if (r_cnt_v == VW'(V_TOTAL - 1)) begin
        r_cnt_v <= '0; r_sub_v <= '0; r_line <= '0; r_cell_row <= '0;
      end else begin
        r_cnt_v <= r_cnt_v + 1'b1;
        if (r_sub_v == SVW'(PIX_H - 1)) begin
          r_sub_v <= '0;
          if (r_line == LW'(FNT_H)) begin
            r_line     <= '0;
            r_cell_row <= r_cell_row + 1'b1;
          end else begin
            r_line <= r_line + 1'b1;
          end
        end else begin
          r_sub_v <= r_sub_v + 1'b1;
        end
      end
    end else begin
      r_cnt_h <= r_cnt_h + 1'b1;
      if (r_sub_h == SHW'(PIX_W - 1)) begin
        r_sub_h <= '0;
        if (r_col == CW'(FNT_W)) begin
          r_col      <= '0;
          r_cell_col <= r_cell_col + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        r_sub_h <= r_sub_h + 1'b1;
      end
    end
  end

`ifdef VGA_TEXT_CURSOR_EN
  logic [5:0] r_frame_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (r_cnt_h == HW'(H_TOTAL - 1) && r_cnt_v == VW'(V_TOTAL - 1)) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end
  assign w_cur = r_frame_cnt[5] && (r_cell_row == VW'(cursor_row)) &&
                 (r_cell_col == HW'(cursor_col)) &&
                 (r_col != CW'(FNT_W)) && (r_line != LW'(FNT_H));
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{cursor_col, cursor_row};
  assign w_cur = 1'b0;
`endif

  always_comb begin
    w_a0      = '0;
    w_a0.cur  = w_cur;
    w_a0.fs   = (r_cnt_h == '0) && (r_cnt_v == '0);
    w_a0.vs   = (r_cnt_v >= VW'(RES_V + BLK_VF)) && (r_cnt_v < VW'(RES_V + BLK_VF + BLK_VT));
    w_a0.hs   = (r_cnt_h >= HW'(RES_H + BLK_HF)) && (r_cnt_h < HW'(RES_H + BLK_HF + BLK_HT));
    w_a0.grid = (r_cell_col < HW'(COLS)) && (r_cell_row < VW'(ROWS));
    w_a0.vis  = (r_cnt_h < HW'(RES_H)) && (r_cnt_v < VW'(RES_V));
    w_a0.line = r_line;
    w_a0.col  = r_col;
  end

  assign w_glyph_sh = r_glyph3 << r_a3.col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_a3        <= '0;
      r_fg2       <= '0;
      r_bg2       <= '0;
      r_fg3       <= '0;
      r_bg3       <= '0;
      r_glyph3    <= '0;
      txt_addr    <= '0;
      font_addr   <= '0;
      RGB         <= '0;
      HSYNC       <= ~SYNC_POL;
      VSYNC       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      r_vld    <= {r_vld[2:1], 1'b1};
      r_a1     <= w_a0;
      txt_addr <= TXT_ADDR_W'(r_cell_row) * TXT_ADDR_W'(COLS) + TXT_ADDR_W'(r_cell_col);

      r_a2      <= r_a1;
      r_fg2     <= txt_data[CHR_BITS+2:CHR_BITS];
      r_bg2     <= txt_data[CHR_BITS+5:CHR_BITS+3];
      font_addr <= FONT_ADDR_W'(r_a1.line) * FONT_ADDR_W'(FNT_C) +
                   FONT_ADDR_W'(txt_data[CHR_BITS-1:0]);

      r_a3     <= r_a2;
      r_fg3    <= r_a2.cur ? r_bg2 : r_fg2;
      r_bg3    <= r_a2.cur ? r_fg2 : r_bg2;
      r_glyph3 <= font_q;

      // Pixel priority: blanking/outside grid, then gap column/line, then glyph bit.
      if (!r_vld[3] || !r_a3.vis || !r_a3.grid) begin
        RGB <= 3'b000;
      end else if (r_a3.col == CW'(FNT_W) || r_a3.line == LW'(FNT_H)) begin
        RGB <= r_bg3;
      end else begin
        RGB <= w_glyph_sh[FNT_W-1] ? r_fg3 : r_bg3;
      end
      HSYNC       <= (r_vld[3] && r_a3.hs) ? SYNC_POL : ~SYNC_POL;
      VSYNC       <= (r_vld[3] && r_a3.vs) ? SYNC_POL : ~SYNC_POL;
      frame_start <= r_vld[3] && r_a3.fs;
    end
  end
endmodule

// File: tb/tb_vga_text_renderer.sv
// tb/tb_vga_text_renderer.sv - scoreboard bench for vga_text_renderer (short vertical timing)
module tb_vga_text_renderer;
  localparam int H_TOTAL = 1056;
  localparam int RES_V   = 40;
  localparam int BLK_VF  = 1;
  localparam int BLK_VT  = 4;
  localparam int BLK_VB  = 3;
  localparam int V_TOTAL = 48;
  localparam int ROWS    = 2;
  localparam int PIX_H   = 2;
  localparam int CELL_V  = 7 * PIX_H;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] txt_addr;
  logic [9:0] txt_data;
  logic [6:0] font_addr;
  logic [3:0] font_q;
  logic [3:0] cursor_col = 4'd1;
  logic [0:0] cursor_row = 1'b0;
  logic [2:0] RGB;
  logic       HSYNC, VSYNC, frame_start;

  logic [9:0] txt_mem [512];
  logic [3:0] rom [128];
  assign txt_data = txt_mem[txt_addr];
  assign font_q   = rom[font_addr];

  exp_t q[$];
  int   fs_cyc[$];
  int   n_asrt = 0, n_fail = 0;
  int   mh, mv, cyc, hs_cnt, vs_cnt, pfa, ph, pv;
  bit   pav;
  logic [2:0] cell00 [5];

  always #5 clk = ~clk;

  vga_text_renderer #(.RES_V(RES_V), .BLK_VF(BLK_VF), .BLK_VT(BLK_VT), .BLK_VB(BLK_VB),
                      .ROWS(ROWS), .PIX_H(PIX_H)) dut (
    .clk(clk), .rst_n(rst_n), .txt_addr(txt_addr), .txt_data(txt_data),
    .font_addr(font_addr), .font_q(font_q), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .RGB(RGB), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                     input int h, input int v);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s h=%0d v=%0d observed=%0h expected=%0h", tag, h, v, obs, exp);
    end
  endtask

  function automatic exp_t model(int h, int v);
    exp_t e;
    int cc, cr, col, line;
    logic [9:0] ent;
    logic [3:0] g;
    e = '0;
    e.h = 11'(h);
    e.v = 10'(v);
    cc = h / 50; cr = v / CELL_V;
    col = (h % 50) / 10; line = (v % CELL_V) / PIX_H;
    if (h < 800 && v < RES_V && cc < 16 && cr < ROWS) begin
      ent = txt_mem[cr * 16 + cc];
      if (col == 4 || line == 6) e.rgb = ent[9:7];
      else begin
        g = rom[line * 16 + int'(ent[3:0])];
        e.rgb = g[3 - col] ? ent[6:4] : ent[9:7];
      end
    end
    e.hs = (h >= 840 && h < 968);
    e.vs = (v >= RES_V + BLK_VF && v < RES_V + BLK_VF + BLK_VT);
    e.fs = (h == 0 && v == 0);
    return e;
  endfunction

  task automatic restart_model();
    exp_t idle;
    idle = '0;
    idle.h = 11'h7FF;
    idle.v = 10'h3FF;
    q.delete();
    fs_cyc.delete();
    repeat (3) q.push_back(idle);
    mh = 0; mv = 0; cyc = 0; hs_cnt = 0; vs_cnt = 0; pav = 0; ph = -1; pv = -1;
  endtask

  task automatic step();
    exp_t d;
    int ta, fa, ch, cv;
    bit av;
    logic [9:0] ent;
    @(posedge clk);
    q.push_back(model(mh, mv));
    av = (mh < 800 && mv < RES_V && mh / 50 < 16 && mv / CELL_V < ROWS);
    ta = (mv / CELL_V) * 16 + mh / 50;
    ent = txt_mem[ta];
    fa = ((mv % CELL_V) / PIX_H) * 16 + int'(ent[3:0]);
    ch = mh; cv = mv;
    mh++;
    if (mh == H_TOTAL) begin
      mh = 0; mv++;
      if (mv == V_TOTAL) mv = 0;
    end
    @(negedge clk);
    cyc++;
    d = q.pop_front();
    chk("rgb", 32'(RGB), 32'(d.rgb), int'(d.h), int'(d.v));
    chk("hsync", 32'(HSYNC), 32'(d.hs), int'(d.h), int'(d.v));
    chk("vsync", 32'(VSYNC), 32'(d.vs), int'(d.h), int'(d.v));
    chk("frame_start", 32'(frame_start), 32'(d.fs), int'(d.h), int'(d.v));
    if (av) chk("txt_addr", 32'(txt_addr), 32'(ta), ch, cv);
    if (pav) chk("font_addr", 32'(font_addr), 32'(pfa), ph, pv);
    if (ph == 50 && pv == 4) chk("font_addr_37", 32'(font_addr), 32'd37, ph, pv);
    if (d.v == 0 && d.h < 50 && d.h % 10 == 0)
      chk("cell00_line0", 32'(RGB), 32'(cell00[d.h / 10]), int'(d.h), int'(d.v));
    pav = av; pfa = fa; ph = ch; pv = cv;
    if (cyc <= FRAME) begin
      if (HSYNC) hs_cnt++;
      if (VSYNC) vs_cnt++;
    end
    if (frame_start) fs_cyc.push_back(cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rgb"}, 32'(RGB), 32'd0, -1, -1);
    chk({tag, "_hsync"}, 32'(HSYNC), 32'd0, -1, -1);
    chk({tag, "_vsync"}, 32'(VSYNC), 32'd0, -1, -1);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0, -1, -1);
    chk({tag, "_txt_addr"}, 32'(txt_addr), 32'd0, -1, -1);
    chk({tag, "_font_addr"}, 32'(font_addr), 32'd0, -1, -1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) txt_mem[i] = 10'($urandom);
    for (int i = 0; i < 128; i++) rom[i] = 4'($urandom);
    txt_mem[0] = {3'b001, 3'b100, 4'd3};
    txt_mem[1] = {3'($urandom), 3'($urandom), 4'd5};
    rom[3] = 4'b1010;
    cell00[0] = 3'b100; cell00[1] = 3'b001; cell00[2] = 3'b100;
    cell00[3] = 3'b001; cell00[4] = 3'b001;

    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    chk_reset_outputs("por_hold");
    restart_model();
    rst_n = 1'b1;

    repeat (FRAME + 20 * H_TOTAL + 300) step();
    chk("hsync_clks_per_frame", 32'(hs_cnt), 32'(128 * V_TOTAL), -1, -1);
    chk("vsync_clks_per_frame", 32'(vs_cnt), 32'(BLK_VT * H_TOTAL), -1, -1);
    chk("frame_start_count", 32'(fs_cyc.size()), 32'd2, -1, -1);
    if (fs_cyc.size() >= 2) begin
      chk("first_frame_start_latency", 32'(fs_cyc[0]), 32'd4, -1, -1);
      chk("frame_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'(FRAME), -1, -1);
    end

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    chk_reset_outputs("mid_reset_hold");
    restart_model();
    rst_n = 1'b1;

    repeat (2 * H_TOTAL) step();
    chk("restart_frame_start_count", 32'(fs_cyc.size()), 32'd1, -1, -1);
    if (fs_cyc.size() >= 1)
      chk("restart_frame_start_latency", 32'(fs_cyc[0]), 32'd4, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
